// File: rtl/stream_mux_rr.sv
// stream_mux_rr: packet-locked stream multiplexer with fixed-select or
// round-robin arbitration feeding a registered output stage.
module stream_mux_rr #(
    parameter int N        = 1,
    parameter int CHANNELS = 32,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      select,
    input  logic [CHANNELS*N-1:0] in_data,
    input  logic [CHANNELS-1:0]   in_valid,
    input  logic [CHANNELS-1:0]   in_last,
    output logic [CHANNELS-1:0]   in_ready,
    output logic [N-1:0]          out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_channel,
    output logic                  busy
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   CH_LIM  = (SEL_W + 1)'(CHANNELS);

    state_t           state;
    state_t           state_nx;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] grant_nx;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_nx;
    logic [SEL_W-1:0] rr_pick;
    logic [SEL_W-1:0] scan;
    logic             rr_found;
    logic             sel_ok;
    logic [N-1:0]     g_data;
    logic             g_valid;
    logic             g_last;
    logic             g_ready;
    logic             accept;

    // Signals of the channel currently holding the grant
    always_comb begin
        g_data  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                g_data  = in_data[i*N +: N];
                g_valid = in_valid[i];
                g_last  = in_last[i];
            end
        end
    end

    // Scan wraps at CHANNELS, not at 2^SEL_W
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        scan     = rr_ptr;
        for (int k = 0; k < CHANNELS; k++) begin
            scan = (scan == LAST_CH) ? '0 : scan + 1'b1;
            if (!rr_found && in_valid[scan]) begin
                rr_found = 1'b1;
                rr_pick  = scan;
            end
        end
    end

    assign sel_ok  = {1'b0, select} < CH_LIM;
    assign g_ready = ~out_valid | out_ready;
    assign accept  = (state == LOCKED) && g_valid && g_ready;
    assign busy    = (state == LOCKED);

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (state == LOCKED && grant == SEL_W'(i)) begin
                in_ready[i] = g_ready;
            end
        end
    end

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        rr_nx    = rr_ptr;
        unique case (state)
            IDLE: begin
                unique case (1'b1)
                    !mode: begin
                        if (sel_ok && in_valid[select]) begin
                            grant_nx = select;
                            state_nx = LOCKED;
                        end
                    end
                    mode: begin
                        if (rr_found) begin
                            grant_nx = rr_pick;
                            state_nx = LOCKED;
                        end
                    end
                endcase
            end
            LOCKED: begin
                if (accept && g_last) begin
                    rr_nx    = grant;
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= LAST_CH;
        end else begin
            state  <= state_nx;
            grant  <= grant_nx;
            rr_ptr <= rr_nx;
        end
    end

    // Load and drain may coincide, giving one beat per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            out_channel <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_data    <= g_data;
            out_last    <= g_last;
            out_channel <= grant;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomized bench for stream_mux_rr: a packet-level arbitration model
// predicts every output beat, a separate monitor checks what comes out.
module tb_stream_mux_rr;

    localparam int N  = 8;
    localparam int CH = 32;
    localparam int SW = 5;
    localparam int C2 = 20;

    typedef struct packed {
        logic [SW-1:0] c;
        logic          l;
        logic [N-1:0]  d;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            mode;
    logic [SW-1:0]   select;
    logic [CH*N-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_last;
    logic [CH-1:0]   in_ready;
    logic [N-1:0]    out_data;
    logic            out_valid;
    logic            out_last;
    logic            out_ready;
    logic [SW-1:0]   out_channel;
    logic            busy;

    logic            b_mode;
    logic [SW-1:0]   b_select;
    logic [C2*N-1:0] b_in_data;
    logic [C2-1:0]   b_in_valid;
    logic [C2-1:0]   b_in_last;
    logic [C2-1:0]   b_in_ready;
    logic [N-1:0]    b_out_data;
    logic            b_out_valid;
    logic            b_out_last;
    logic            b_out_ready;
    logic [SW-1:0]   b_out_channel;
    logic            b_busy;

    always #5 clk = ~clk;

    stream_mux_rr #(.N(N), .CHANNELS(CH)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .select(select),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready),
        .out_channel(out_channel), .busy(busy)
    );

    stream_mux_rr #(.N(N), .CHANNELS(C2)) u_small (
        .clk(clk), .rst(rst), .mode(b_mode), .select(b_select),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last),
        .in_ready(b_in_ready), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_last(b_out_last),
        .out_ready(b_out_ready), .out_channel(b_out_channel),
        .busy(b_busy)
    );

    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    beat_t       expq[$];
    logic [N:0]  pq[CH][$];
    logic [N:0]  mq[CH][$];
    int          pend[CH];
    logic [CH-1:0] acc;
    logic [CH-1:0] midpkt;
    logic [CH-1:0] distract;
    int          model_ptr;
    int          rdy_pct;
    bit          rnd_valid;
    int          tcyc[$];
    logic [SW-1:0] tch[$];
    logic        tbusy[$];
    beat_t       hold;
    bit          holding = 1'b0;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic bit pending();
        for (int c = 0; c < CH; c++)
            if (pq[c].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock of producer/consumer driving; returns at negedge+3
    task automatic step();
        @(negedge clk);
        if (rst) begin
            acc    = '0;
            midpkt = '0;
        end
        for (int c = 0; c < CH; c++) begin
            if (acc[c] && pq[c].size() > 0) begin
                midpkt[c] = ~pq[c][0][N];
                void'(pq[c].pop_front());
            end
        end
        for (int c = 0; c < CH; c++) begin
            if (pq[c].size() > 0) begin
                in_valid[c] = (midpkt[c] && rnd_valid) ?
                              ($urandom_range(0, 3) != 0) : 1'b1;
                in_data[c*N +: N] = pq[c][0][N-1:0];
                in_last[c] = pq[c][0][N];
            end else begin
                in_valid[c] = distract[c];
                in_data[c*N +: N] = N'($urandom);
                in_last[c] = 1'($urandom);
            end
        end
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        #1 acc = in_valid & in_ready;
        #2;
    endtask

    task automatic flush();
        expq.delete();
        for (int c = 0; c < CH; c++) begin
            pq[c].delete();
            mq[c].delete();
            pend[c] = 0;
        end
    endtask

    task automatic add_pkt(int c, int len, int d0);
        logic [N:0] b;
        for (int i = 0; i < len; i++) begin
            b[N-1:0] = (d0 < 0) ? N'($urandom) : N'(d0 + i);
            b[N] = (i == len - 1);
            pq[c].push_back(b);
            mq[c].push_back(b);
        end
        pend[c]++;
    endtask

    // Whole packets leave in arbitration order; no cycle-level detail
    task automatic run_model();
        int c;
        int total = 0;
        logic [N:0] b;
        beat_t e;
        for (int i = 0; i < CH; i++) total += pend[i];
        while (total > 0) begin
            if (mode) begin
                c = model_ptr;
                do c = (c + 1) % CH; while (pend[c] == 0);
            end else begin
                c = int'(select);
            end
            if (pend[c] == 0) break;
            do begin
                b = mq[c].pop_front();
                e.c = SW'(c);
                e.l = b[N];
                e.d = b[N-1:0];
                expq.push_back(e);
            end while (!b[N]);
            pend[c]--;
            total--;
            model_ptr = c;
        end
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((expq.size() != 0 || pending()) && n < budget) begin
            step();
            n++;
        end
        vectors++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain: %0d beats outstanding after %0d cycles, expected 0",
                     expq.size(), budget);
            flush();
            rst = 1'b1;
            step();
            rst = 1'b0;
            model_ptr = CH - 1;
        end
        distract = '0;
        repeat (3) step();
    endtask

    always @(negedge clk) begin
        beat_t e;
        #2;
        cyc++;
        if (rst) begin
            holding = 1'b0;
        end else begin
            if (holding)
                chk("hold", {out_valid, out_last, out_channel, out_data},
                    {1'b1, hold.l, hold.c, hold.d});
            chk("ready_onehot0", 32'($onehot0(in_ready)), 1);
            if (out_valid && !out_ready)
                chk("ready_under_bp", in_ready, 0);
            if (out_valid && out_ready) begin
                tcyc.push_back(cyc);
                tch.push_back(out_channel);
                tbusy.push_back(busy);
                if (expq.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL extra_beat: got ch %0d data %0h, expected no beat",
                             out_channel, out_data);
                end else begin
                    e = expq.pop_front();
                    chk("beat", {out_channel, out_last, out_data},
                        {e.c, e.l, e.d});
                end
            end
            holding = out_valid && !out_ready;
            hold.c = out_channel;
            hold.l = out_last;
            hold.d = out_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        rst = 1'b1;
        mode = 1'b0;
        select = '0;
        distract = '0;
        acc = '0;
        midpkt = '0;
        rdy_pct = 100;
        rnd_valid = 1'b0;
        model_ptr = CH - 1;
        b_mode = 1'b0;
        b_select = '0;
        b_in_data = '0;
        b_in_valid = '0;
        b_in_last = '0;
        b_out_ready = 1'b1;
        repeat (3) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_channel", out_channel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_small_valid", b_out_valid, 0);
        rst = 1'b0;

        // 20-channel instance: out-of-range and invalid select stay idle
        for (int c = 0; c < C2; c++) b_in_data[c*N +: N] = N'(8'hC0 + c);
        b_select = 5'd31;
        b_in_valid = '1;
        b_in_last = '1;
        repeat (4) begin
            step();
            chk("oor_busy", b_busy, 0);
            chk("oor_in_ready", b_in_ready, 0);
            chk("oor_out_valid", b_out_valid, 0);
        end
        b_select = 5'd19;
        b_in_valid[19] = 1'b0;
        repeat (3) begin
            step();
            chk("noval_busy", b_busy, 0);
            chk("noval_in_ready", b_in_ready, 0);
        end
        b_in_valid[19] = 1'b1;
        step();
        chk("sel19_busy", b_busy, 1);
        chk("sel19_in_ready", b_in_ready, 32'h80000);
        step();
        chk("sel19_beat", {b_busy, b_out_valid, b_out_last, b_out_channel, b_out_data},
            {1'b0, 1'b1, 1'b1, 5'd19, 8'hD3});
        b_in_valid = '0;
        b_in_valid[0] = 1'b1;
        b_in_valid[5] = 1'b1;
        b_mode = 1'b1;
        step();
        chk("wrap20_busy", b_busy, 1);
        chk("wrap20_in_ready", b_in_ready, 1);
        b_in_valid = '0;

        // Fixed select, 3-beat packet at full rate
        mode = 1'b0;
        select = 5'd5;
        base = tcyc.size();
        add_pkt(5, 3, 8'hA1);
        run_model();
        drain(200);
        chk("t2_beats", tcyc.size() - base, 3);
        if (tcyc.size() >= base + 3) begin
            chk("t2_gap1", tcyc[base+1] - tcyc[base], 1);
            chk("t2_gap2", tcyc[base+2] - tcyc[base+1], 1);
            chk("t2_busy_mid", tbusy[base+1], 1);
            chk("t2_busy_end", tbusy[base+2], 0);
        end

        // Reset lands after the first beat of a 3-beat packet
        select = 5'd9;
        base = tcyc.size();
        add_pkt(9, 3, 8'h31);
        run_model();
        n = 0;
        while (tcyc.size() == base && n < 50) begin
            step();
            n++;
        end
        chk("t6_first_beat", tcyc.size() - base, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_in_ready", in_ready, 0);
        chk("t6_busy", busy, 0);
        chk("t6_out_data", {out_last, out_channel, out_data}, 0);
        flush();
        model_ptr = CH - 1;
        step();
        rst = 1'b0;

        // All channels request; first round-robin grant is channel 0
        mode = 1'b1;
        base = tcyc.size();
        for (int c = 0; c < CH; c++) add_pkt(c, 1, 8'h40 + c);
        run_model();
        drain(400);
        if (tcyc.size() > base) chk("t1_first_grant", tch[base], 0);

        // Three requesters with single-beat packets
        base = tcyc.size();
        add_pkt(3, 1, 8'h03);
        add_pkt(3, 1, 8'h13);
        add_pkt(7, 1, 8'h07);
        add_pkt(31, 1, 8'h1F);
        run_model();
        drain(200);
        chk("t3_beats", tcyc.size() - base, 4);
        if (tcyc.size() >= base + 4) begin
            chk("t3_order", {tch[base], tch[base+1], tch[base+2], tch[base+3]},
                {5'd3, 5'd7, 5'd31, 5'd3});
            for (int i = 1; i < 4; i++)
                chk("t3_gap", tcyc[base+i] - tcyc[base+i-1], 2);
        end

        // Consumer stalls during a 2-beat packet
        mode = 1'b0;
        select = 5'd12;
        add_pkt(12, 2, 8'h5A);
        run_model();
        rdy_pct = 0;
        repeat (6) step();
        chk("t4_stall", {out_valid, out_data, in_ready}, {1'b1, 8'h5A, 32'h0});
        rdy_pct = 100;
        drain(200);

        // Randomized mixed-mode phases
        for (int p = 0; p < 14; p++) begin
            rnd_valid = 1'b1;
            case ($urandom_range(0, 2))
                0: rdy_pct = 35;
                1: rdy_pct = 70;
                default: rdy_pct = 100;
            endcase
            if ($urandom_range(0, 2) == 0) begin
                mode = 1'b0;
                select = SW'($urandom_range(0, CH - 1));
                distract = $urandom;
                distract[select] = 1'b0;
                repeat ($urandom_range(1, 3))
                    add_pkt(int'(select), $urandom_range(1, 4), -1);
            end else begin
                mode = 1'b1;
                distract = '0;
                for (int c = 0; c < CH; c++)
                    if ($urandom_range(0, 3) == 0)
                        repeat ($urandom_range(1, 2))
                            add_pkt(c, $urandom_range(1, 4), -1);
            end
            run_model();
            drain(3000);
            chk("idle_after_phase", busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
